// File: rtl/conv_mem_loader_if.sv
// Stream-in / memory-write / engine-control bundle for conv_mem_loader.
// master = stream source and engine side, slave = the loader.
interface conv_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              load_req;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              filter_write;
    logic              pic_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              start_everything;
    logic              conv_done;
    logic              busy;
    logic              err;

    modport master (
        output load_req, in_valid, in_data, conv_done,
        input  in_ready, filter_write, pic_write, mem_addr, mem_wdata,
               start_everything, busy, err
    );

    modport slave (
        input  load_req, in_valid, in_data, conv_done,
        output in_ready, filter_write, pic_write, mem_addr, mem_wdata,
               start_everything, busy, err
    );
endinterface

// File: rtl/conv_mem_loader.sv
// Streams filter bytes, picture bytes and a checksum into the filter/picture
// memories, then kicks the convolution engine if the checksum closes to zero.
module conv_mem_loader #(
    parameter int FILT_WORDS = 16,
    parameter int PIC_WORDS  = 64,
    parameter int ADDR_W     = 8
) (
    input logic              clk,
    input logic              rst,
    conv_mem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD_FILT, LOAD_PIC, CHECK, START, WAIT_DONE, ERR
    } state_t;

    localparam logic [ADDR_W-1:0] FILT_LAST = ADDR_W'(FILT_WORDS - 1);
    localparam logic [ADDR_W-1:0] PIC_LAST  = ADDR_W'(PIC_WORDS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_sum;
    logic [7:0]        r_wdata;
    logic              r_in_ready;
    logic              r_fw;
    logic              r_pw;
    logic              r_start;
    logic              r_busy;
    logic              r_err;

    logic              w_hs;
    logic [7:0]        w_sum_next;

    assign w_hs       = bus.in_valid & r_in_ready;
    assign w_sum_next = r_sum + bus.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_sum      <= '0;
            r_wdata    <= '0;
            r_in_ready <= 1'b0;
            r_fw       <= 1'b0;
            r_pw       <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Strobes are single-cycle: only a handshake this cycle raises one.
            r_fw <= 1'b0;
            r_pw <= 1'b0;
            case (r_state)
                IDLE, ERR: begin
                    if (bus.load_req) begin
                        r_state    <= LOAD_FILT;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD_FILT: begin
                    if (w_hs) begin
                        r_fw    <= 1'b1;
                        r_addr  <= r_cnt;
                        r_wdata <= bus.in_data;
                        r_sum   <= w_sum_next;
                        if (r_cnt == FILT_LAST) begin
                            r_state <= LOAD_PIC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end
                end
                LOAD_PIC: begin
                    if (w_hs) begin
                        r_pw    <= 1'b1;
                        r_addr  <= r_cnt;
                        r_wdata <= bus.in_data;
                        r_sum   <= w_sum_next;
                        if (r_cnt == PIC_LAST) begin
                            r_state <= CHECK;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end
                end
                CHECK: begin
                    // Checksum byte is chosen so the whole frame sums to 0 mod 256.
                    if (w_hs) begin
                        r_in_ready <= 1'b0;
                        if (w_sum_next == 8'd0) begin
                            r_state <= START;
                            r_start <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_DONE;
                    r_start <= 1'b0;
                end
                WAIT_DONE: begin
                    if (bus.conv_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_start    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready         = r_in_ready;
    assign bus.filter_write     = r_fw;
    assign bus.pic_write        = r_pw;
    assign bus.mem_addr         = r_addr;
    assign bus.mem_wdata        = r_wdata;
    assign bus.start_everything = r_start;
    assign bus.busy             = r_busy;
    assign bus.err              = r_err;
endmodule

// File: tb/tb_conv_mem_loader.sv
// Randomized frame-level bench for conv_mem_loader with a byte-index reference
// model compared against every output on every falling edge.
module tb_conv_mem_loader;
    localparam int FILT = 16;
    localparam int PIC  = 64;
    localparam int NB   = FILT + PIC + 1;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_START = 2;
    localparam int M_WAIT  = 3;
    localparam int M_ERR   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_mem_loader_if #(.ADDR_W(8)) bus ();

    conv_mem_loader #(.FILT_WORDS(FILT), .PIC_WORDS(PIC), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int         m_mode = M_IDLE;
    int         m_idx  = 0;
    logic [7:0] m_sum  = 8'd0;
    bit         m_hs   = 1'b0;
    logic       e_ready = 1'b0, e_fw = 1'b0, e_pw = 1'b0, e_start = 1'b0;
    logic       e_busy = 1'b0, e_err = 1'b0;
    logic [7:0] e_addr = 8'd0, e_wdata = 8'd0;

    // frame data and what the DUT actually wrote
    logic [7:0] fr   [0:NB-1];
    logic [7:0] fmem [0:FILT-1];
    logic [7:0] pmem [0:PIC-1];
    int n_fw = 0, n_pw = 0, n_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // The model tracks the frame as a byte index: [0,FILT) filter, then picture, then checksum.
    task automatic model_step();
        logic [7:0] d;
        if (rst) begin
            m_mode = M_IDLE; m_idx = 0; m_sum = 8'd0; m_hs = 1'b0;
            e_ready = 0; e_fw = 0; e_pw = 0; e_start = 0; e_busy = 0; e_err = 0;
            e_addr = 8'd0; e_wdata = 8'd0;
            return;
        end
        d    = bus.in_data;
        m_hs = bus.in_valid && e_ready;
        e_fw = 1'b0;
        e_pw = 1'b0;
        case (m_mode)
            M_IDLE, M_ERR: if (bus.load_req) begin
                m_mode = M_LOAD; m_idx = 0; m_sum = 8'd0; e_err = 1'b0;
            end
            M_LOAD: if (m_hs) begin
                if (m_idx < FILT) begin
                    e_fw = 1'b1; e_addr = 8'(m_idx); e_wdata = d;
                end else if (m_idx < FILT + PIC) begin
                    e_pw = 1'b1; e_addr = 8'(m_idx - FILT); e_wdata = d;
                end else if (8'(m_sum + d) == 8'd0) begin
                    m_mode = M_START;
                end else begin
                    m_mode = M_ERR; e_err = 1'b1;
                end
                m_sum = m_sum + d;
                m_idx++;
            end
            M_START: m_mode = M_WAIT;
            M_WAIT:  if (bus.conv_done) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        e_ready = (m_mode == M_LOAD);
        e_busy  = (m_mode == M_LOAD) || (m_mode == M_START) || (m_mode == M_WAIT);
        e_start = (m_mode == M_START);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // single compare process: every output, every cycle, plus write capture
    initial begin
        #2;
        forever begin
            @(negedge clk);
            chk("in_ready",         bus.in_ready,         e_ready);
            chk("filter_write",     bus.filter_write,     e_fw);
            chk("pic_write",        bus.pic_write,        e_pw);
            chk("mem_addr",         bus.mem_addr,         e_addr);
            chk("mem_wdata",        bus.mem_wdata,        e_wdata);
            chk("start_everything", bus.start_everything, e_start);
            chk("busy",             bus.busy,             e_busy);
            chk("err",              bus.err,              e_err);
            if (bus.filter_write === 1'b1) begin
                if (bus.mem_addr < FILT) fmem[bus.mem_addr] = bus.mem_wdata;
                n_fw++;
            end
            if (bus.pic_write === 1'b1) begin
                if (bus.mem_addr < PIC) pmem[bus.mem_addr] = bus.mem_wdata;
                n_pw++;
            end
            if (bus.start_everything === 1'b1) n_start++;
        end
    end

    task automatic fill_nominal();
        for (int i = 0; i < FILT; i++) fr[i] = 8'(i + 1);
        for (int i = 0; i < PIC; i++) fr[FILT + i] = 8'h01;
        fr[NB-1] = 8'h38;
    endtask

    task automatic fill_random(input bit good);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < NB - 1; i++) begin
            fr[i] = 8'($urandom_range(0, 255));
            s = s + fr[i];
        end
        fr[NB-1] = (8'd0 - s) + (good ? 8'd0 : 8'(1 + $urandom_range(0, 254)));
    endtask

    // stall: 0 none, 1 = valid pattern 1,0,0 per byte, 2 = random gaps before each byte
    task automatic send_byte(input logic [7:0] d, input int stall);
        int n;
        if (stall == 2) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!m_hs && n < 50);
        if (!m_hs) chk("handshake_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(0, 255));
        if (stall == 1) begin repeat (2) begin @(posedge clk); #1; end end
    endtask

    task automatic start_frame();
        for (int i = 0; i < FILT; i++) fmem[i] = 8'hxx;
        for (int i = 0; i < PIC; i++) pmem[i] = 8'hxx;
        n_fw = 0; n_pw = 0; n_start = 0;
        bus.load_req = 1'b1;
        @(posedge clk); #1;
        bus.load_req = 1'b0;
        chk("err_clear_on_load_req", bus.err, 0);
        chk("busy_after_load_req",   bus.busy, 1);
    endtask

    task automatic send_frame(input int stall, input bit inject);
        start_frame();
        for (int i = 0; i < NB; i++) begin
            if (inject && i == 3)        bus.conv_done = 1'b1;
            if (inject && i == FILT + 5) bus.load_req  = 1'b1;
            send_byte(fr[i], stall);
            bus.conv_done = 1'b0;
            bus.load_req  = 1'b0;
        end
    endtask

    task automatic finish_frame(input bit good);
        repeat (3) begin @(posedge clk); #1; end
        chk("filter_strobes", n_fw, FILT);
        chk("pic_strobes",    n_pw, PIC);
        for (int i = 0; i < FILT; i++) chk("filter_mem", fmem[i], fr[i]);
        for (int i = 0; i < PIC; i++)  chk("pic_mem",    pmem[i], fr[FILT + i]);
        if (good) begin
            chk("start_pulses", n_start, 1);
            chk("busy_wait_done", bus.busy, 1);
            chk("err_good", bus.err, 0);
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            bus.conv_done = 1'b1;
            @(posedge clk); #1;
            bus.conv_done = 1'b0;
            chk("busy_after_done", bus.busy, 0);
        end else begin
            chk("start_pulses_bad", n_start, 0);
            chk("err_bad", bus.err, 1);
            chk("busy_bad", bus.busy, 0);
        end
    endtask

    initial begin
        bus.load_req = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.conv_done = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        chk("reset_busy",     bus.busy,     0);
        chk("reset_in_ready", bus.in_ready, 0);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // nominal frame
        fill_nominal();
        send_frame(0, 1'b0);
        finish_frame(1'b1);

        // bad checksum, then a nominal frame must clear err
        fill_nominal();
        fr[NB-1] = 8'h39;
        send_frame(0, 1'b0);
        finish_frame(1'b0);
        fill_nominal();
        send_frame(0, 1'b0);
        finish_frame(1'b1);

        // stalled stream 1,0,0,1
        fill_nominal();
        send_frame(1, 1'b0);
        finish_frame(1'b1);

        // stray load_req in picture phase and conv_done in filter phase
        fill_nominal();
        send_frame(0, 1'b1);
        finish_frame(1'b1);

        // reset after picture byte 10, asserted between clock edges
        fill_nominal();
        start_frame();
        for (int i = 0; i < FILT + 11; i++) send_byte(fr[i], 0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", bus.in_ready,         0);
        chk("async_rst_fw",       bus.filter_write,     0);
        chk("async_rst_pw",       bus.pic_write,        0);
        chk("async_rst_addr",     bus.mem_addr,         0);
        chk("async_rst_wdata",    bus.mem_wdata,        0);
        chk("async_rst_start",    bus.start_everything, 0);
        chk("async_rst_busy",     bus.busy,             0);
        chk("async_rst_err",      bus.err,              0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send_frame(0, 1'b0);
        finish_frame(1'b1);

        // random frames, random stalls, random checksum faults
        for (int f = 0; f < 6; f++) begin
            bit good;
            good = ($urandom_range(0, 3) != 0);
            bus.conv_done = 1'b1;
            @(posedge clk); #1;
            bus.conv_done = 1'b0;
            fill_random(good);
            send_frame(2, 1'b0);
            finish_frame(good);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/conv_mem_loader.md
CONV_MEM_LOADER -- requirements
Module: conv_mem_loader

Interface
REQ-001 Parameter FILT_WORDS, default 16, SHALL set the number of filter bytes per frame (4x4 filter).
REQ-002 Parameter PIC_WORDS, default 64, SHALL set the number of picture bytes per frame.
REQ-003 Parameter ADDR_W, default 8, SHALL set the memory address width; FILT_WORDS and PIC_WORDS SHALL each be <= 2^ADDR_W.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 load_req  input  1  SHALL be a one-cycle request to begin loading a frame.
REQ-007 in_valid  input  1  SHALL qualify in_data.
REQ-008 in_data  input  8  SHALL carry stream bytes in order: filter bytes, then picture bytes, then one checksum byte.
REQ-009 in_ready  output  1  SHALL indicate that the loader accepts in_data this cycle.
REQ-010 filter_write  output  1  SHALL be the filter-memory write strobe.
REQ-011 pic_write  output  1  SHALL be the picture-memory write strobe.
REQ-012 mem_addr  output  ADDR_W  SHALL be the write address for the asserted strobe.
REQ-013 mem_wdata  output  8  SHALL be the write data for the asserted strobe.
REQ-014 start_everything  output  1  SHALL be a one-cycle pulse that starts the convolution engine.
REQ-015 conv_done  input  1  SHALL be the completion indication from the convolution engine.
REQ-016 busy  output  1  SHALL be high in every state except IDLE and ERR.
REQ-017 err  output  1  SHALL be a sticky checksum-failure flag.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_FILT, LOAD_PIC, CHECK, START, WAIT_DONE and ERR.
REQ-019 A handshake SHALL occur on any cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD_FILT, LOAD_PIC and CHECK.
REQ-020 IDLE or ERR with load_req=1 -> LOAD_FILT; byte counter=0, running sum=0, err=0.
REQ-021 load_req SHALL be ignored in all other states.
REQ-022 Each LOAD_FILT handshake SHALL register filter_write=1, mem_addr=counter and mem_wdata=in_data for exactly the next cycle (latency 1), then increment the counter.
REQ-023 The handshake carrying byte FILT_WORDS-1 SHALL move the FSM to LOAD_PIC with counter=0.
REQ-024 LOAD_PIC SHALL behave the same way using pic_write, and its final byte (PIC_WORDS-1) SHALL move the FSM to CHECK.
REQ-025 Every handshake in LOAD_FILT and LOAD_PIC SHALL add in_data to an 8-bit running sum (mod 256, carry discarded).
REQ-026 The CHECK handshake SHALL NOT write memory.
REQ-027 If (sum + in_data) mod 256 == 0 at the CHECK handshake, the FSM SHALL go to START; otherwise it SHALL go to ERR and set err=1.
REQ-028 START SHALL assert start_everything for exactly one cycle, then go to WAIT_DONE.
REQ-029 WAIT_DONE SHALL hold until conv_done=1, then go to IDLE.
REQ-030 A conv_done pulse in any other state SHALL be ignored.
REQ-031 in_valid=0 cycles SHALL stall the stream: the counter, sum and state SHALL hold, and no strobe SHALL be produced.
REQ-032 filter_write and pic_write SHALL never be high in the same cycle; both SHALL be 0 on every non-handshake cycle.
REQ-033 mem_addr and mem_wdata SHALL hold their last values when no strobe is asserted.
REQ-034 The counter SHALL never exceed FILT_WORDS-1 in LOAD_FILT or PIC_WORDS-1 in LOAD_PIC (no wrap within a phase).

Reset
REQ-035 Asserting rst SHALL immediately force state=IDLE and clear the counter, sum, in_ready, filter_write, pic_write, mem_addr, mem_wdata, start_everything, busy and err to 0, independent of clk.
REQ-036 A reset asserted mid-load SHALL discard the partial frame; the first load_req after deassertion SHALL start a fresh frame at filter address 0.

Verification
REQ-037 Nominal frame: load_req, filter bytes 1..16, picture bytes all 0x01 (64 bytes), checksum 0x38 -> 16 filter_write (addr 0..15), then 64 pic_write (addr 0..63), then start_everything for 1 cycle, busy=1 until conv_done.
REQ-038 Bad checksum: same frame with checksum 0x39 -> no start_everything, err=1, busy=0, and err clears on the next load_req.
REQ-039 Stalls: in_valid toggled 1,0,0,1 per byte -> exactly 80 strobes with contiguous addresses, and the same final result as REQ-037.
REQ-040 Ignored inputs: load_req pulsed during LOAD_PIC and conv_done pulsed during LOAD_FILT -> no state change, and the frame completes normally.
REQ-041 Reset mid-frame: rst asserted after picture byte 10, then a new nominal frame -> all outputs are 0 during reset, and the new frame writes from filter addr 0 with a correct start.
REQ-042 Boundary: filter byte 15 handshake -> the next accepted byte produces pic_write at addr 0, and the checksum byte produces no strobe.
